// File: rtl/vga_framebuffer_scanout.sv
// 160x120x3-bit framebuffer with a plot write port, a clear sweep, and 640x480@60 VGA
// scan-out. Each framebuffer cell is shown as a 4x4 block of screen pixels.
module vga_framebuffer_scanout #(
    parameter int unsigned FB_WIDTH  = 160,
    parameter int unsigned FB_HEIGHT = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [2:0] colour,
    input  logic       clear,
    output logic       busy,
    output logic [7:0] drop_count,
    output logic       frame_tick,
    output logic       vblank,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int unsigned FB_DEPTH     = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned CNT_W        = 10;
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 751;
    localparam int unsigned H_LAST       = 799;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 491;
    localparam int unsigned V_LAST       = 524;

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                busy_q, busy_d;
    logic [7:0]          drop_count_q, drop_count_d;
    logic                pix_en_q, pix_en_d;
    logic [CNT_W-1:0]    h_count_q, h_count_d;
    logic [CNT_W-1:0]    v_count_q, v_count_d;
    logic                frame_tick_q, frame_tick_d;
    logic                vblank_q, vblank_d;
    logic                hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d;
    logic                hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d;

    logic [2:0]          mem [FB_DEPTH];
    logic [2:0]          rd_pix_q;
    logic [ADDR_W-1:0]   rd_addr_c;
    logic                wr_en_c;
    logic [ADDR_W-1:0]   wr_addr_c;
    logic [2:0]          wr_data_c;
    logic                in_range_c;
    logic                accept_c;
    logic                drop_c;

    // Clear FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    // Clear FSM next state; a clear request during the sweep is ignored
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                clr_addr_d = '0;
                if (clear) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_addr_q == ADDR_W'(FB_DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear FSM outputs: memory write port arbitration and busy
    always_comb begin
        busy_d     = (state_d == ST_CLEAR);
        in_range_c = (32'(x) < FB_WIDTH) && (32'(y) < FB_HEIGHT);
        accept_c   = plot && in_range_c && !busy_q;
        drop_c     = plot && !accept_c;
        wr_en_c    = 1'b0;
        wr_addr_c  = '0;
        wr_data_c  = '0;
        if (state_q == ST_CLEAR) begin
            wr_en_c   = 1'b1;
            wr_addr_c = clr_addr_q;
        end else if (accept_c) begin
            wr_en_c   = 1'b1;
            wr_addr_c = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
            wr_data_c = colour;
        end
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_c && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end

    // Raster counters advance at half the system clock
    always_comb begin
        pix_en_d     = ~pix_en_q;
        h_count_d    = h_count_q;
        v_count_d    = v_count_q;
        frame_tick_d = 1'b0;
        if (pix_en_q) begin
            if (h_count_q == CNT_W'(H_LAST)) begin
                h_count_d = '0;
                if (v_count_q == CNT_W'(V_LAST)) v_count_d = '0;
                else v_count_d = v_count_q + CNT_W'(1);
                if (v_count_q == CNT_W'(V_ACTIVE - 1)) frame_tick_d = 1'b1;
            end else begin
                h_count_d = h_count_q + CNT_W'(1);
            end
        end
        vblank_d = (v_count_d >= CNT_W'(V_ACTIVE));
    end

    // Blanking addresses are forced to 0 so the read never leaves the array
    always_comb begin
        rd_addr_c = '0;
        if (h_count_q < CNT_W'(H_ACTIVE) && v_count_q < CNT_W'(V_ACTIVE))
            rd_addr_c = ADDR_W'(v_count_q >> 2) * ADDR_W'(FB_WIDTH) + ADDR_W'(h_count_q >> 2);
    end

    // Sync/blank go through two pixel-tick stages to line up with the memory read
    always_comb begin
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        blank1_d  = blank1_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        if (pix_en_q) begin
            hs1_d     = !(h_count_q >= CNT_W'(H_SYNC_START) && h_count_q <= CNT_W'(H_SYNC_END));
            vs1_d     = !(v_count_q >= CNT_W'(V_SYNC_START) && v_count_q <= CNT_W'(V_SYNC_END));
            blank1_d  = (h_count_q < CNT_W'(H_ACTIVE)) && (v_count_q < CNT_W'(V_ACTIVE));
            hs_d      = hs1_q;
            vs_d      = vs1_q;
            blank_n_d = blank1_q;
            r_d       = blank1_q ? {8{rd_pix_q[2]}} : 8'h00;
            g_d       = blank1_q ? {8{rd_pix_q[1]}} : 8'h00;
            b_d       = blank1_q ? {8{rd_pix_q[0]}} : 8'h00;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_q <= '0;
            pix_en_q     <= 1'b0;
            h_count_q    <= '0;
            v_count_q    <= '0;
            frame_tick_q <= 1'b0;
            vblank_q     <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            blank1_q     <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blank_n_q    <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
        end else begin
            drop_count_q <= drop_count_d;
            pix_en_q     <= pix_en_d;
            h_count_q    <= h_count_d;
            v_count_q    <= v_count_d;
            frame_tick_q <= frame_tick_d;
            vblank_q     <= vblank_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            blank1_q     <= blank1_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_n_q    <= blank_n_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
        end
    end

    // Framebuffer: not reset; same-edge write and read returns the old data
    always_ff @(posedge clock) begin
        if (wr_en_c) mem[wr_addr_c] <= wr_data_c;
        if (pix_en_q) rd_pix_q <= mem[rd_addr_c];
    end

    assign busy        = busy_q;
    assign drop_count  = drop_count_q;
    assign frame_tick  = frame_tick_q;
    assign vblank      = vblank_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule
